// File: rtl/ddco_pkg.sv
// Shared definitions for the decoder select sequencer: mode encodings, FSM states
// and mode normalisation.
package ddco_pkg;

  localparam logic [1:0] MODE_UP       = 2'b00;
  localparam logic [1:0] MODE_DOWN     = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN_UP   = 2'b01,
    ST_RUN_DOWN = 2'b10
  } state_t;

  // The reserved encoding 11 behaves exactly like up, so it is folded here once.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    logic [1:0] res;
    case (mode)
      MODE_DOWN:     res = MODE_DOWN;
      MODE_PINGPONG: res = MODE_PINGPONG;
      default:       res = MODE_UP;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/decoder_select_sequencer_step_prescaler.sv
// Mod-DIV prescaler: counts 0..DIV-1 while enabled and flags the terminal count
// as a step tick. clr forces the count back to zero.
module step_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  logic [CW-1:0] count_r;

  // Terminal-count detect; a clear in the same cycle suppresses the tick.
  always_comb begin
    tick = en && !clr && (count_r == LAST_CNT);
  end

  // Counter register with clear priority over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= CNT_ZERO;
    end else if (clr) begin
      count_r <= CNT_ZERO;
    end else if (en) begin
      if (count_r == LAST_CNT) begin
        count_r <= CNT_ZERO;
      end else begin
        count_r <= count_r + CNT_ONE;
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/decoder_select_sequencer.sv
// Select-code generator for the 2-to-4 decoder: steps SEL up, down or ping-pong at a
// DIV-cycle rate, with load and start/stop control. For W=2, SEL[1] feeds D0, SEL[0] feeds D1.
module decoder_select_sequencer
  import ddco_pkg::*;
#(
  parameter int W   = 2,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         START,
  input  logic         STOP,
  input  logic [1:0]   MODE,
  input  logic         LOAD,
  input  logic [W-1:0] LOAD_VAL,
  output logic [W-1:0] SEL,
  output logic         STEP,
  output logic         WRAP,
  output logic         BUSY
);

  localparam logic [W-1:0] SEL_ZERO = {W{1'b0}};
  localparam logic [W-1:0] SEL_ONE  = W'(1'b1);
  localparam logic [W-1:0] SEL_MAX  = {W{1'b1}};

  state_t       state_r;
  logic [1:0]   mode_r;
  logic [W-1:0] sel_r;
  logic         step_r;
  logic         wrap_r;
  logic         busy_r;
  logic         pre_en_s;
  logic         pre_clr_s;
  logic         tick_s;

  // Prescaler runs only in RUN states; STOP, LOAD and IDLE all restart it from zero.
  always_comb begin
    pre_en_s  = (state_r != ST_IDLE);
    pre_clr_s = STOP || LOAD || (state_r == ST_IDLE);
  end

  step_prescaler #(
    .DIV (DIV)
  ) u_step_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en_s),
    .clr  (pre_clr_s),
    .tick (tick_s)
  );

  // Sequencer FSM, SEL register and registered STEP/WRAP/BUSY flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      mode_r  <= MODE_UP;
      sel_r   <= SEL_ZERO;
      step_r  <= 1'b0;
      wrap_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      step_r <= 1'b0;
      wrap_r <= 1'b0;
      if (STOP) begin
        state_r <= ST_IDLE;
        busy_r  <= 1'b0;
      end else begin
        if (LOAD) begin
          sel_r <= LOAD_VAL;
        end
        case (state_r)
          ST_IDLE: begin
            if (START) begin
              mode_r  <= norm_mode(MODE);
              busy_r  <= 1'b1;
              state_r <= (norm_mode(MODE) == MODE_DOWN) ? ST_RUN_DOWN : ST_RUN_UP;
            end
          end
          ST_RUN_UP: begin
            // A load in the same cycle wins over the step.
            if (tick_s && !LOAD) begin
              step_r <= 1'b1;
              if (sel_r != SEL_MAX) begin
                sel_r <= sel_r + SEL_ONE;
              end else begin
                wrap_r <= 1'b1;
                if (mode_r == MODE_PINGPONG) begin
                  sel_r   <= SEL_MAX - SEL_ONE;
                  state_r <= ST_RUN_DOWN;
                end else begin
                  sel_r <= SEL_ZERO;
                end
              end
            end
          end
          ST_RUN_DOWN: begin
            if (tick_s && !LOAD) begin
              step_r <= 1'b1;
              if (sel_r != SEL_ZERO) begin
                sel_r <= sel_r - SEL_ONE;
              end else begin
                wrap_r <= 1'b1;
                if (mode_r == MODE_PINGPONG) begin
                  sel_r   <= SEL_ONE;
                  state_r <= ST_RUN_UP;
                end else begin
                  sel_r <= SEL_MAX;
                end
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SEL  = sel_r;
  assign STEP = step_r;
  assign WRAP = wrap_r;
  assign BUSY = busy_r;

endmodule

// File: tb/tb_decoder_select_sequencer.sv
// Directed bench: three sequencers (DIV=4,1,2) share one stimulus stream and are checked
// every cycle against a behavioural model, plus hand-computed literal expectations.
module tb_decoder_select_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic       LOAD = 1'b0;
  logic [1:0] MODE = 2'b00;
  logic [1:0] LOAD_VAL = 2'b00;

  logic [1:0] sel_w  [3];
  logic       step_w [3];
  logic       wrap_w [3];
  logic       busy_w [3];

  decoder_select_sequencer #(.W(2), .DIV(4)) u_d4 (
    .clk(clk), .rst(rst), .START(START), .STOP(STOP), .MODE(MODE), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL), .SEL(sel_w[0]), .STEP(step_w[0]), .WRAP(wrap_w[0]), .BUSY(busy_w[0]));
  decoder_select_sequencer #(.W(2), .DIV(1)) u_d1 (
    .clk(clk), .rst(rst), .START(START), .STOP(STOP), .MODE(MODE), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL), .SEL(sel_w[1]), .STEP(step_w[1]), .WRAP(wrap_w[1]), .BUSY(busy_w[1]));
  decoder_select_sequencer #(.W(2), .DIV(2)) u_d2 (
    .clk(clk), .rst(rst), .START(START), .STOP(STOP), .MODE(MODE), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL), .SEL(sel_w[2]), .STEP(step_w[2]), .WRAP(wrap_w[2]), .BUSY(busy_w[2]));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model state per instance
  int div_tab [3] = '{4, 1, 2};
  int m_sel  [3];
  int m_cnt  [3];
  int m_mode [3];
  bit m_run  [3];
  bit m_up   [3];
  bit m_step [3];
  bit m_wrap [3];
  bit model_valid = 1'b0;

  // Literal expectation mailbox, written only by the stimulus process
  bit    lit_active = 1'b0;
  string lit_name = "";
  int    lit_k = 0;
  int    lit_sel = 0;
  int    lit_step = 0;
  int    lit_wrap = 0;
  int    lit_busy = 0;

  int pp_sel  [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
  int pp_wrap [8] = '{0, 0, 0, 0, 1, 0, 0, 1};

  // Model: cycles since start/last step; a step is taken on the DIV-th running cycle.
  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        m_step[k] = 1'b0;
        m_wrap[k] = 1'b0;
        if (rst) begin
          m_run[k] = 1'b0; m_sel[k] = 0; m_cnt[k] = 0; m_up[k] = 1'b1; m_mode[k] = 0;
        end else if (STOP) begin
          m_run[k] = 1'b0; m_cnt[k] = 0;
        end else begin
          if (LOAD) begin
            m_sel[k] = int'(LOAD_VAL);
            m_cnt[k] = 0;
          end
          if (!m_run[k]) begin
            if (START) begin
              m_run[k]  = 1'b1;
              m_mode[k] = (MODE == 2'd3) ? 0 : int'(MODE);
              m_up[k]   = (m_mode[k] != 1);
              m_cnt[k]  = 0;
            end
          end else if (!LOAD) begin
            m_cnt[k] = m_cnt[k] + 1;
            if (m_cnt[k] == div_tab[k]) begin
              m_cnt[k]  = 0;
              m_step[k] = 1'b1;
              if (m_up[k]) begin
                if (m_sel[k] == 3) begin
                  m_wrap[k] = 1'b1;
                  if (m_mode[k] == 2) begin m_sel[k] = 2; m_up[k] = 1'b0; end
                  else m_sel[k] = 0;
                end else m_sel[k] = m_sel[k] + 1;
              end else begin
                if (m_sel[k] == 0) begin
                  m_wrap[k] = 1'b1;
                  if (m_mode[k] == 2) begin m_sel[k] = 1; m_up[k] = 1'b1; end
                  else m_sel[k] = 3;
                end else m_sel[k] = m_sel[k] - 1;
              end
            end
          end
        end
      end
      model_valid = 1'b1;
    end
  end

  task automatic cmp(input string nm, input int k, input logic [31:0] got, input int want);
    checks = checks + 1;
    if (got !== 32'(want)) begin
      failures = failures + 1;
      $display("FAIL %s dut%0d got=%0d want=%0d", nm, k, got, want);
    end
  endtask

  // Compare process: model every cycle, plus any posted literal expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        for (int k = 0; k < 3; k++) begin
          cmp("model_sel",  k, 32'(sel_w[k]),  m_sel[k]);
          cmp("model_step", k, 32'(step_w[k]), int'(m_step[k]));
          cmp("model_wrap", k, 32'(wrap_w[k]), int'(m_wrap[k]));
          cmp("model_busy", k, 32'(busy_w[k]), int'(m_run[k]));
        end
      end
      if (lit_active) begin
        cmp({lit_name, "_sel"},  lit_k, 32'(sel_w[lit_k]),  lit_sel);
        cmp({lit_name, "_step"}, lit_k, 32'(step_w[lit_k]), lit_step);
        cmp({lit_name, "_wrap"}, lit_k, 32'(wrap_w[lit_k]), lit_wrap);
        cmp({lit_name, "_busy"}, lit_k, 32'(busy_w[lit_k]), lit_busy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_now(input string nm, input int k, input int s, input int st,
                            input int w, input int b);
    lit_name = nm; lit_k = k; lit_sel = s; lit_step = st; lit_wrap = w; lit_busy = b;
    lit_active = 1'b1;
    @(negedge clk);
    #1;
    lit_active = 1'b0;
  endtask

  task automatic stop_pulse();
    STOP = 1'b1; tick(); STOP = 1'b0;
  endtask

  task automatic load_start(input logic [1:0] mode);
    LOAD = 1'b1; LOAD_VAL = 2'd0; START = 1'b1; MODE = mode;
    tick();
    LOAD = 1'b0; START = 1'b0;
  endtask

  initial begin
    ticks(3);
    expect_now("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Up count, DIV=4
    START = 1'b1; MODE = 2'b00; tick(); START = 1'b0;
    expect_now("t1_start", 0, 0, 0, 0, 1);
    ticks(3);  expect_now("t1_hold", 0, 0, 0, 0, 1);
    tick();    expect_now("t1_s1",   0, 1, 1, 0, 1);
    ticks(4);  expect_now("t1_s2",   0, 2, 1, 0, 1);
    ticks(4);  expect_now("t1_s3",   0, 3, 1, 0, 1);
    ticks(4);  expect_now("t1_wrap", 0, 0, 1, 1, 1);
    stop_pulse();
    expect_now("t1_stop", 0, 0, 0, 0, 0);

    // Ping-pong, DIV=1, started together with a load of 0
    load_start(2'b10);
    expect_now("t2_e0", 1, 0, 0, 0, 1);
    for (int i = 1; i < 8; i++) begin
      tick();
      expect_now("t2_pp", 1, pp_sel[i], 1, pp_wrap[i], 1);
    end
    stop_pulse();

    // Down from 0, DIV=2; MODE change mid-run must be ignored
    load_start(2'b01);
    expect_now("t3_e0", 2, 0, 0, 0, 1);
    MODE = 2'b10;
    tick();    expect_now("t3_e1",   2, 0, 0, 0, 1);
    tick();    expect_now("t3_wrap", 2, 3, 1, 1, 1);
    ticks(2);  expect_now("t3_s2",   2, 2, 1, 0, 1);
    ticks(2);  expect_now("t3_s1",   2, 1, 1, 0, 1);
    ticks(2);  expect_now("t3_s0",   2, 0, 1, 0, 1);
    ticks(2);  expect_now("t3_mode_ignored", 2, 3, 1, 1, 1);
    stop_pulse();

    // Load mid-run on the cycle a step was due, DIV=4
    load_start(2'b00);
    ticks(4);  expect_now("t4_s1", 0, 1, 1, 0, 1);
    ticks(3);
    LOAD = 1'b1; LOAD_VAL = 2'd2; tick(); LOAD = 1'b0;
    expect_now("t4_load", 0, 2, 0, 0, 1);
    START = 1'b1; MODE = 2'b01; tick(); START = 1'b0; MODE = 2'b00;
    expect_now("t4_start_ignored", 0, 2, 0, 0, 1);
    ticks(2);  expect_now("t4_hold",  0, 2, 0, 0, 1);
    tick();    expect_now("t4_after_load", 0, 3, 1, 0, 1);
    stop_pulse();

    // STOP with SEL=1 and prescaler at 2, then resume with reserved mode 11
    load_start(2'b00);
    ticks(4);  expect_now("t5_s1", 0, 1, 1, 0, 1);
    ticks(2);
    stop_pulse();
    expect_now("t5_stop", 0, 1, 0, 0, 0);
    ticks(10); expect_now("t5_hold", 0, 1, 0, 0, 0);
    STOP = 1'b1; START = 1'b1; tick(); STOP = 1'b0; START = 1'b0;
    expect_now("t5_stop_start", 0, 1, 0, 0, 0);
    START = 1'b1; MODE = 2'b11; tick(); START = 1'b0; MODE = 2'b00;
    expect_now("t5_resume", 0, 1, 0, 0, 1);
    ticks(4);  expect_now("t5_resume_step", 0, 2, 1, 0, 1);
    stop_pulse();

    // Reset during ping-pong descent, DIV=1
    load_start(2'b10);
    ticks(4);  expect_now("t6_desc", 1, 2, 1, 1, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    expect_now("t6_rst", 1, 0, 0, 0, 0);
    START = 1'b1; MODE = 2'b10; tick(); START = 1'b0;
    expect_now("t6_restart", 1, 0, 0, 0, 1);
    tick();    expect_now("t6_up", 1, 1, 1, 0, 1);

    ticks(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decoder_select_sequencer.md
Name: decoder_select_sequencer

Overview:
- Sequential stage directly upstream of the 2-to-4 decoder; generates the binary select code the decoder consumes.
- Steps the select code through its range at a programmable rate in up, down or ping-pong order. Supports load, start/stop control and step/wrap event pulses.
- Used to sweep decoder outputs in lab builds and to drive one-hot enables in the DDCO datapath exercises.

Parameters:
- W, 2, select width; decoder has 2**W outputs.
- DIV, 4, clock cycles per step (DIV >= 1); prescaler counts 0..DIV-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- START  input  1  pulse: leave IDLE and begin stepping
- STOP  input  1  pulse: return to IDLE; SEL holds its value
- MODE  input  2  00 up, 01 down, 10 ping-pong, 11 reserved (treated as up); sampled only when START is accepted
- LOAD  input  1  synchronous load of SEL from LOAD_VAL
- LOAD_VAL  input  W  load value
- SEL  output  W  select code. For W=2, SEL[1] drives decoder D0 and SEL[0] drives decoder D1.
- STEP  output  1  one-cycle pulse in the cycle SEL changes due to stepping
- WRAP  output  1  one-cycle pulse when a step wraps (up: MAX->0, down: 0->MAX) or reverses direction (ping-pong)
- BUSY  output  1  high in any RUN state

Behaviour:
- Reset: state=IDLE, SEL=0, prescaler=0, STEP=0, WRAP=0, BUSY=0, direction=up. rst has priority over every other input, including mid-run.
- States:
  - IDLE: SEL is held.
  - RUN_UP
  - RUN_DOWN
- IDLE -> RUN_UP on START when MODE is 00, 10 or 11.
- IDLE -> RUN_DOWN on START when MODE is 01.
- Stored mode bits are latched at START; MODE changes during a run are ignored.
- Prescaler:
  - In RUN states it increments each cycle.
  - When prescaler == DIV-1, it resets to 0 and a step occurs in that same cycle.
  - The first step therefore happens DIV cycles after START is accepted.
  - With DIV=1, a step occurs every cycle.
- Step in RUN_UP:
  - SEL < MAX: SEL+1.
  - SEL == MAX, mode up: SEL=0, WRAP=1.
  - SEL == MAX, mode ping-pong: SEL=MAX-1, go to RUN_DOWN, WRAP=1.
- Step in RUN_DOWN:
  - SEL > 0: SEL-1.
  - SEL == 0, mode down: SEL=MAX, WRAP=1.
  - SEL == 0, mode ping-pong: SEL=1, go to RUN_UP, WRAP=1.
- STEP and WRAP are registered. They are high in the cycle after the step edge, aligned with the new SEL value.
- Arithmetic is modulo 2**W; no overflow state exists.
- STOP: next state is IDLE, prescaler=0, pending step is discarded, SEL unchanged.
- Priority when signals coincide: rst > STOP > LOAD > START > step.
- LOAD in any state:
  - SEL=LOAD_VAL, prescaler=0, no STEP/WRAP pulse that cycle.
  - State is unchanged, so a run continues from the loaded value.
- START while already running is ignored.
- START and LOAD in the same cycle: the load is applied and START is also accepted (from IDLE).
- STOP and START in the same cycle: stays or goes to IDLE.
- W=1 ping-pong degenerates to alternating 0/1, with WRAP on every step.

Decomposition:
- Shared package ddco_pkg:
  - MODE encoding constants: MODE_UP, MODE_DOWN, MODE_PINGPONG.
  - State enumeration: ST_IDLE, ST_RUN_UP, ST_RUN_DOWN.
- One natural sub-module: step_prescaler. It is a mod-DIV counter with enable and clear, and outputs a tick pulse.
- The FSM and SEL register stay in the top level.
- The integration top instantiates decoder_select_sequencer feeding the existing decoder.

Test Plan:
- Reset, then START with MODE=00, DIV=4: SEL is 0 for 4 cycles, then 1, 2, 3, 0 every 4 cycles. STEP pulses each change; WRAP pulses on the 3->0 step.
- START with MODE=10, DIV=1: SEL sequence 0,1,2,3,2,1,0,1. WRAP pulses on the 3->2 and 0->1 steps; BUSY=1 throughout.
- START with MODE=01 from SEL=0, DIV=2: after 2 cycles SEL=3 with WRAP=1, then 2, 1, 0.
- LOAD_VAL=2 with LOAD mid-run (MODE=00, DIV=4): SEL=2 on the next cycle with no STEP pulse. The next step comes 4 cycles later (SEL=3).
- STOP when SEL=1 and the prescaler is at 2: state is IDLE, BUSY=0, SEL stays 1 indefinitely. A following START resumes from 1.
- rst asserted during ping-pong descent at SEL=2: next cycle SEL=0, BUSY=0, STEP=0, WRAP=0. A later START with MODE=10 begins upward.
